// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer for the 8-bit RISC CPU.
// An eight-phase counter and a sticky halt flag drive the combinational datapath strobes.
module cpu_sequencer (
   input  logic       clk,
   input  logic       rst_,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic [2:0] phase,
   output logic       halted
);

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;

   logic [2:0] phase_q, phase_d;
   logic       halted_q, halted_d;
   logic       aluop;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         phase_q  <= 3'd0;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Halting freezes the counter at phase 4 instead of advancing.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (ena && !halted_q) begin
         if (phase_q == 3'd4 && opcode == HLT) begin
            halted_d = 1'b1;
         end else begin
            phase_d = phase_q + 3'd1;
         end
      end
   end

   assign aluop = (opcode == ADD) || (opcode == AND) ||
                  (opcode == XOR) || (opcode == LDA);

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (halted_q) begin
         halt = 1'b1;
      end else begin
         case (phase_q)
            3'd0: sel = 1'b1;
            3'd1: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            3'd2, 3'd3: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            3'd4: begin
               inc_pc = 1'b1;
               halt   = (opcode == HLT);
            end
            3'd5: rd = aluop;
            3'd6: begin
               rd     = aluop;
               inc_pc = (opcode == SKZ) && zero;
               ld_pc  = (opcode == JMP);
               data_e = (opcode == STO);
            end
            default: begin
               rd     = aluop;
               ld_ac  = aluop;
               inc_pc = (opcode == JMP);
               ld_pc  = (opcode == JMP);
               wr     = (opcode == STO);
               data_e = (opcode == STO);
            end
         endcase
      end
   end

   assign phase  = phase_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: strobe vectors per phase are hand-written constants.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0] phase;
   logic       halted;
   logic [8:0] strb;

   int n_chk = 0;
   int n_err = 0;

   cpu_sequencer dut (
      .clk(clk), .rst_(rst_), .ena(ena), .opcode(opcode), .zero(zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
      .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
      .phase(phase), .halted(halted)
   );

   always #5 clk = ~clk;

   // Bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
   assign strb = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   localparam logic [8:0] S_P0   = 9'b100000000;
   localparam logic [8:0] S_P1   = 9'b110000000;
   localparam logic [8:0] S_P23  = 9'b111000000;
   localparam logic [8:0] S_P4   = 9'b000100000;
   localparam logic [8:0] S_P4H  = 9'b000110000;
   localparam logic [8:0] S_NONE = 9'b000000000;
   localparam logic [8:0] S_HALT = 9'b000010000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp holds eight 9-bit strobe vectors, phase 0 in the low bits.
   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input logic [71:0] exp);
      opcode = op;
      zero   = z;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("%s phase%0d", name, i), {29'd0, phase}, i);
         check($sformatf("%s strb%0d", name, i), {23'd0, strb}, {23'd0, exp[i*9 +: 9]});
         tick();
      end
   endtask

   initial begin
      rst_   = 1'b0;
      ena    = 1'b1;
      opcode = 3'b010;
      zero   = 1'b0;

      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst phase", {29'd0, phase}, 0);
         check("rst strb", {23'd0, strb}, {23'd0, S_P0});
         check("rst halted", {31'd0, halted}, 0);
      end
      rst_ = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("count %0d", i), {29'd0, phase}, i % 8);
      end

      run_instr("ADD", 3'b010, 1'b0,
                {9'b010000010, 9'b010000000, 9'b010000000, S_P4, S_P23, S_P23, S_P1, S_P0});
      run_instr("STO", 3'b110, 1'b1,
                {9'b000000101, 9'b000000100, S_NONE, S_P4, S_P23, S_P23, S_P1, S_P0});
      run_instr("JMP", 3'b111, 1'b0,
                {9'b000101000, 9'b000001000, S_NONE, S_P4, S_P23, S_P23, S_P1, S_P0});
      run_instr("SKZ1", 3'b001, 1'b1,
                {S_NONE, 9'b000100000, S_NONE, S_P4, S_P23, S_P23, S_P1, S_P0});
      run_instr("SKZ0", 3'b001, 1'b0,
                {S_NONE, S_NONE, S_NONE, S_P4, S_P23, S_P23, S_P1, S_P0});

      // HLT: walk to phase 4, then halt sticks regardless of inputs.
      opcode = 3'b000;
      for (int i = 0; i < 4; i++) tick();
      check("hlt p4 phase", {29'd0, phase}, 4);
      check("hlt p4 strb", {23'd0, strb}, {23'd0, S_P4H});
      check("hlt p4 halted", {31'd0, halted}, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         check($sformatf("halted%0d flag", i), {31'd0, halted}, 1);
         check($sformatf("halted%0d phase", i), {29'd0, phase}, 4);
         check($sformatf("halted%0d strb", i), {23'd0, strb}, {23'd0, S_HALT});
         ena    = i[0];
         opcode = 3'(i + 1);
         zero   = ~i[0];
         tick();
      end
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      ena  = 1'b1;
      check("unhalt phase", {29'd0, phase}, 0);
      check("unhalt halted", {31'd0, halted}, 0);
      check("unhalt strb", {23'd0, strb}, {23'd0, S_P0});

      // Stall at phase 3, then reset in phase 6 of a JMP.
      opcode = 3'b111;
      zero   = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall%0d phase", i), {29'd0, phase}, 3);
         check($sformatf("stall%0d strb", i), {23'd0, strb}, {23'd0, S_P23});
      end
      ena = 1'b1;
      tick();
      check("resume phase", {29'd0, phase}, 4);
      tick();
      tick();
      check("jmp6 phase", {29'd0, phase}, 6);
      check("jmp6 strb", {23'd0, strb}, {23'd0, 9'b000001000});
      rst_ = 1'b0;
      tick();
      check("midrst phase", {29'd0, phase}, 0);
      check("midrst ld_pc", {31'd0, ld_pc}, 0);
      check("midrst strb", {23'd0, strb}, {23'd0, S_P0});
      rst_ = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Instruction-cycle controller for the 8-bit RISC CPU.
- A 3-bit phase counter walks eight phases per instruction.
- Each phase is decoded together with the instruction-register opcode and the ALU zero flag into the datapath strobes: address mux select, memory read/write, IR/PC/accumulator loads, data bus enable.
- The sequencer owns halt: after an HLT it stops the cycle until reset.

Parameters:
- HLT, 3'b000, halt opcode (ALU PASS0)
- SKZ, 3'b001, skip-if-zero opcode (ALU PASS1)
- ADD, 3'b010, add opcode
- AND, 3'b011, and opcode
- XOR, 3'b100, xor opcode
- LDA, 3'b101, load-accumulator opcode (ALU PASSD)
- STO, 3'b110, store opcode (ALU PASS6)
- JMP, 3'b111, jump opcode (ALU PASS7)

Ports:
- clk  in  1  rising-edge clock
- rst_  in  1  synchronous reset, active low
- ena  in  1  advance enable; low freezes phase
- opcode  in  3  IR opcode field, valid from phase 4
- zero  in  1  ALU zero flag (accumulator == 0)
- sel  out  1  address mux: 1 = PC, 0 = IR operand
- rd  out  1  memory read
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment program counter
- halt  out  1  halt indication
- ld_pc  out  1  load PC from IR operand
- data_e  out  1  drive accumulator onto data bus
- ld_ac  out  1  load accumulator from ALU out
- wr  out  1  memory write
- phase  out  3  current phase
- halted  out  1  sticky halted status

Behaviour:
- Reset is synchronous with the clock: rst_=0 at a rising edge sets phase=0 and halted=0. It overrides ena and any halted state, including mid-instruction.
- Phase advance: when ena=1, halted=0 and rst_=1, phase increments by 1 each edge and wraps 7 -> 0. When ena=0, phase and halted hold.
- Strobes are a combinational decode of phase, opcode and zero. ALUOP = opcode in {ADD, AND, XOR, LDA}. Any strobe not listed for a phase is 0.
  - Phase 0 (INST_ADDR): sel=1.
  - Phase 1 (INST_FETCH): sel=1, rd=1.
  - Phase 2 (INST_LOAD): sel=1, rd=1, ld_ir=1.
  - Phase 3 (IDLE): sel=1, rd=1, ld_ir=1.
  - Phase 4 (OP_ADDR): inc_pc=1; halt=(opcode==HLT).
  - Phase 5 (OP_FETCH): rd=ALUOP.
  - Phase 6 (ALU_OP): rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - Phase 7 (STORE): rd=ALUOP; ld_ac=ALUOP; inc_pc=(opcode==JMP); ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt entry: on an edge with phase==4, opcode==HLT, ena=1 and rst_=1, halted is set to 1 and phase stays 4 (no advance).
- While halted=1:
  - halt=1 and phase holds at 4.
  - All other strobes are 0, including sel.
  - opcode, zero and ena are ignored.
  - Only reset clears this state.
- Reset values: phase=0, halted=0, sel=1, all other strobes 0.
- SKZ with zero=0: no extra inc_pc. Only the phase-4 increment occurs.
- ena dropped mid-instruction: outputs stay equal to the decode of the frozen phase. Strobes are level signals, so the datapath must itself gate loads with ena.
- opcode may change during phases 0–3; the decode uses it only from phase 4 on.
- Opcode values outside the table cannot occur, since every 3-bit code is defined.

Test Plan:
- Reset: hold rst_=0 for 2 edges with ena=1 and opcode=ADD, then release. Required: phase=0, sel=1, all other strobes 0 during reset; phase then counts 1..7, 0.
- ADD instruction with ena=1: phases 0–7 strobes match the table exactly. Required: phase 5 rd=1; phase 7 rd=1, ld_ac=1; wr=0 and data_e=0 throughout.
- STO and JMP:
  - STO: data_e=1 in phases 6–7, wr=1 only in phase 7, ld_ac=0.
  - JMP: ld_pc=1 in phases 6–7, inc_pc=1 in phases 4 and 7.
- SKZ: with zero=1, inc_pc=1 in phases 4 and 6. With zero=0, inc_pc=1 only in phase 4.
- HLT:
  - Phase 4 with opcode=HLT: halt=1 combinationally.
  - Following edges: halted=1, phase stays 4, other strobes 0, unchanged for 10 cycles with toggling ena and opcode.
  - Then rst_=0 for 1 edge: phase=0, halted=0.
- ena stall: drop ena at phase 3 for 3 cycles. Required: phase stays 3 with ld_ir=1 held, then resumes at 4. Also assert rst_=0 at phase 6 of a JMP: next phase=0, ld_pc=0.
